// File: rtl/octal_rr_arbiter.sv
// Round-robin arbiter for eight requesters with a bounded hold quantum.
// Registered one-hot grant plus binary owner index.
module octal_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;

  logic [2:0] owner;
  logic [2:0] nxt;
  logic [7:0] others;

  // First set bit of v scanning upward from start, wrapping mod 8.
  function automatic logic [2:0] pick(
    input logic [7:0] v,
    input logic [2:0] start
  );
    logic [2:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    owner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (gnt_q[i]) owner = owner | 3'(i);
    end
  end

  assign nxt    = owner + 3'd1;
  assign others = req & ~gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 8'd1 << pick(req, ptr_q);
          hold_d  = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          ptr_d  = nxt;
          hold_d = 8'd0;
          if (|others) begin
            gnt_d = 8'd1 << pick(others, nxt);
          end else begin
            gnt_d   = 8'd0;
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_LAST) begin
          // Quantum spent: hand over only if someone else is waiting.
          if (|others) begin
            ptr_d  = nxt;
            gnt_d  = 8'd1 << pick(others, nxt);
            hold_d = 8'd0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = owner;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Directed vector bench for octal_rr_arbiter.
// Main table on MAX_HOLD=4; a hand sequence on MAX_HOLD=1.
module tb_octal_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt, gnt1;
  logic [2:0] gnt_id, gnt_id1;
  logic       gnt_valid, gnt_valid1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  octal_rr_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  octal_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt1), .gnt_id(gnt_id1), .gnt_valid(gnt_valid1)
  );

  task automatic add(input logic r, input logic [7:0] q,
                     input logic [7:0] g, input logic [2:0] i);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.id = i;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(1, 8'h00, 8'h00, 0);
    // single requester, no preemption
    for (int i = 0; i < 10; i++) add(0, 8'h10, 8'h10, 4);
    add(0, 8'h00, 8'h00, 0);
    // early release, ptr=0: 2 wins, then 6 with no bubble
    add(1, 8'h00, 8'h00, 0);
    add(0, 8'h44, 8'h04, 2);
    add(0, 8'h44, 8'h04, 2);
    add(0, 8'h40, 8'h40, 6);
    add(0, 8'h40, 8'h40, 6);
    add(0, 8'h00, 8'h00, 0);
    // late competitor preempts at saturated hold; ptr=4 picks 1
    add(1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) add(0, 8'h08, 8'h08, 3);
    add(0, 8'h0A, 8'h02, 1);
    add(0, 8'h02, 8'h02, 1);
    add(0, 8'h00, 8'h00, 0);
    // reset mid-grant
    add(1, 8'h00, 8'h00, 0);
    add(0, 8'h20, 8'h20, 5);
    add(0, 8'h20, 8'h20, 5);
    add(1, 8'h20, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0);
    add(0, 8'h01, 8'h01, 0);
    add(0, 8'h00, 8'h00, 0);
    // owner 7 released wraps ptr to 0
    add(1, 8'h00, 8'h00, 0);
    add(0, 8'h80, 8'h80, 7);
    add(0, 8'h00, 8'h00, 0);
    add(0, 8'h81, 8'h01, 0);
    add(0, 8'h00, 8'h00, 0);
    // release and reset together: reset wins, ptr back to 0
    add(1, 8'h00, 8'h00, 0);
    add(0, 8'h08, 8'h08, 3);
    add(1, 8'h00, 8'h00, 0);
    add(0, 8'h22, 8'h02, 1);
    add(0, 8'h00, 8'h00, 0);
    // full contention, 4 cycles per owner, wrapping 7 -> 0
    add(1, 8'h00, 8'h00, 0);
    for (int o = 0; o < 9; o++) begin
      logic [2:0] oi;
      logic [7:0] g;
      oi = 3'(o % 8);
      g  = 8'd1 << oi;
      for (int k = 0; k < 4; k++) add(0, 8'hFF, g, oi);
    end
    add(0, 8'h00, 8'h00, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].req);
      chk("gnt", n, gnt, vecs[n].gnt);
      chk("gnt_id", n, 8'(gnt_id), 8'(vecs[n].id));
      chk("gnt_valid", n, 8'(gnt_valid), 8'(vecs[n].gnt != 8'h00));
      if (gnt != 8'h00 && (gnt & (gnt - 8'd1)) != 8'h00) begin
        checks++;
        errors++;
        $display("FAIL onehot step %0d: got %h expected one-hot", n, gnt);
      end
    end

    // MAX_HOLD=1 rotates every cycle between 0 and 7
    drive(1, 8'h00);
    chk("h1_rst", 0, gnt1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] eg;
      logic [2:0] ei;
      eg = (i % 2 == 0) ? 8'h01 : 8'h80;
      ei = (i % 2 == 0) ? 3'd0 : 3'd7;
      drive(0, 8'h81);
      chk("h1_gnt", i, gnt1, eg);
      chk("h1_id", i, 8'(gnt_id1), 8'(ei));
      chk("h1_valid", i, 8'(gnt_valid1), 8'h01);
    end
    drive(0, 8'h00);
    chk("h1_idle", 0, gnt1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
